// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = (a - b - bin) mod 2^size, one bit per clock, LSB first.
// Build option: define SERIAL_SUBTRACTOR_SAT_EN to clamp an underflowing result to zero.
module serial_subtractor #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  input  logic            bin,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] diff,
  output logic            bout
);

  localparam int CW = (size > 1) ? $clog2(size) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(size - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [size-1:0] a_q, a_d;
  logic [size-1:0] b_q, b_d;
  logic [size-1:0] res_q, res_d;
  logic [size-1:0] diff_q, diff_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            brw_q, brw_d;
  logic            bout_q, bout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      fs_s;
  logic [size-1:0] res_upd_s;

  // Single-bit full subtractor: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fs_bit(input logic ai, input logic bi, input logic br);
    fs_bit = {(~ai & bi) | (~(ai ^ bi) & br), ai ^ bi ^ br};
  endfunction

  // Next-state, datapath update and output decode.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    brw_d     = brw_q;
    bout_d    = bout_q;
    fs_s      = fs_bit(a_q[cnt_q], b_q[cnt_q], brw_q);
    res_upd_s = res_q;
    res_upd_s[cnt_q] = fs_s[0];

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = {CW{1'b0}};
          res_d   = {size{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        res_d = res_upd_s;
        brw_d = fs_s[1];
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          cnt_d   = {CW{1'b0}};
          bout_d  = fs_s[1];
`ifdef SERIAL_SUBTRACTOR_SAT_EN
          diff_d  = fs_s[1] ? {size{1'b0}} : res_upd_s;
`else
          diff_d  = res_upd_s;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {size{1'b0}};
      b_q     <= {size{1'b0}};
      res_q   <= {size{1'b0}};
      diff_q  <= {size{1'b0}};
      cnt_q   <= {CW{1'b0}};
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: three instances (size 1, 8, 16), directed
// timing/reset cases on the size-8 instance and randomized vectors on all three.
module tb_serial_subtractor;

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v;
  logic [2:0]  bin_v;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [2:0]  busy_v, done_v, bout_v;
  logic [31:0] diff_v [3];

  logic        busy0, busy1, busy2, done0, done1, done2, bout0, bout1, bout2;
  logic [0:0]  diff0;
  logic [7:0]  diff1;
  logic [15:0] diff2;

  exp_t q0[$], q1[$], q2[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.size(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][0:0]), .b(b_v[0][0:0]),
    .bin(bin_v[0]), .busy(busy0), .done(done0), .diff(diff0), .bout(bout0));
  serial_subtractor #(.size(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
    .bin(bin_v[1]), .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));
  serial_subtractor #(.size(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][15:0]), .b(b_v[2][15:0]),
    .bin(bin_v[2]), .busy(busy2), .done(done2), .diff(diff2), .bout(bout2));

  assign busy_v    = {busy2, busy1, busy0};
  assign done_v    = {done2, done1, done0};
  assign bout_v    = {bout2, bout1, bout0};
  assign diff_v[0] = 32'(diff0);
  assign diff_v[1] = 32'(diff1);
  assign diff_v[2] = 32'(diff2);

  // Reference: plain unsigned arithmetic on wide integers.
  function automatic exp_t ref_model(input int sz, input logic [31:0] a, input logic [31:0] b,
                                     input logic bin);
    exp_t e;
    logic [63:0] mask, t;
    mask = (64'd1 << sz) - 64'd1;
    t    = {32'd0, a} - {32'd0, b} - {63'd0, bin};
    e.d  = 32'(t & mask);
    e.bo = ({32'd0, a} < ({32'd0, b} + {63'd0, bin}));
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    if (e.bo) e.d = 32'd0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] m);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return m;
      default: return $urandom & m;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic void push_exp(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  task automatic check_result(input int id);
    exp_t e;
    int   qs;
    qs = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
    if (qs == 0) begin
      n_checks++;
      $display("FAIL unexpected_done inst%0d: done seen with no pending operation", id);
    end else begin
      case (id)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("diff_inst%0d", id), diff_v[id], e.d);
      chk($sformatf("bout_inst%0d", id), 32'(bout_v[id]), 32'(e.bo));
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) check_result(i);
    end
  end

  // One size-8 operation with cycle-accurate busy/done checks; entered at posedge+1.
  task automatic run_timed(input logic [31:0] a, input logic [31:0] b, input logic bin);
    a_v[1] = a; b_v[1] = b; bin_v[1] = bin; start_v[1] = 1'b1;
    @(posedge clk);
    push_exp(1, ref_model(8, a, b, bin));
    #1;
    start_v[1] = 1'b0;
    a_v[1] = $urandom & 32'hFF; b_v[1] = $urandom & 32'hFF; bin_v[1] = 1'($urandom);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("busy_cycle%0d", c), 32'(busy_v[1]), 32'(c <= 8));
      chk($sformatf("done_cycle%0d", c), 32'(done_v[1]), 32'(c == 9));
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int id, input int sz, input int n);
    logic [31:0] m, a, b;
    logic        bi;
    bit          got;
    m = 32'((64'd1 << sz) - 64'd1);
    for (int i = 0; i < n; i++) begin
      a = pick(m); b = pick(m); bi = 1'($urandom);
      a_v[id] = a; b_v[id] = b; bin_v[id] = bi; start_v[id] = 1'b1;
      @(posedge clk);
      push_exp(id, ref_model(sz, a, b, bi));
      #1;
      start_v[id] = 1'($urandom);
      a_v[id] = $urandom & m; b_v[id] = $urandom & m; bin_v[id] = 1'($urandom);
      @(posedge clk); #1;
      start_v[id] = 1'b0;
      got = 1'b0;
      for (int c = 0; c < sz + 4 && !got; c++) begin
        @(negedge clk);
        if (done_v[id]) got = 1'b1;
      end
      chk($sformatf("done_within_bound_inst%0d", id), 32'(got), 32'd1);
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] na, nb;
    logic        nbi;
    rst = 1'b1; start_v = 3'b000; bin_v = 3'b000;
    for (int i = 0; i < 3; i++) begin a_v[i] = 32'd0; b_v[i] = 32'd0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy_v), 32'd0);
    chk("reset_done", 32'(done_v), 32'd0);
    chk("reset_diff", diff_v[1], 32'd0);
    chk("reset_bout", 32'(bout_v), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Start on the first edge after reset release, then the corner vectors.
    run_timed(32'h5A, 32'h3C, 1'b0);
    run_timed(32'h00, 32'h01, 1'b0);
    run_timed(32'hFF, 32'hFF, 1'b1);
    run_timed(32'h80, 32'h7F, 1'b1);

    // Back-to-back with start held high; operands scrambled during SHIFT.
    a_v[1] = 32'h9C; b_v[1] = 32'h2D; bin_v[1] = 1'b1; start_v[1] = 1'b1;
    @(posedge clk);
    push_exp(1, ref_model(8, 32'h9C, 32'h2D, 1'b1));
    for (int i = 0; i < 4; i++) begin
      #1;
      a_v[1] = $urandom & 32'hFF; b_v[1] = $urandom & 32'hFF; bin_v[1] = 1'($urandom);
      repeat (8) @(posedge clk);
      #1;
      na = $urandom & 32'hFF; nb = $urandom & 32'hFF; nbi = 1'($urandom);
      a_v[1] = na; b_v[1] = nb; bin_v[1] = nbi;
      @(negedge clk);
      chk($sformatf("b2b_done_%0d", i), 32'(done_v[1]), 32'd1);
      @(posedge clk);
      push_exp(1, ref_model(8, na, nb, nbi));
    end
    #1 start_v[1] = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Reset in cycle 4 of an operation aborts it and clears the outputs.
    run_timed(32'hC3, 32'h21, 1'b0);
    a_v[1] = 32'h77; b_v[1] = 32'h11; bin_v[1] = 1'b0; start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 5; c <= 14; c++) begin
      @(negedge clk);
      chk($sformatf("abort_busy_c%0d", c), 32'(busy_v[1]), 32'd0);
      chk($sformatf("abort_done_c%0d", c), 32'(done_v[1]), 32'd0);
      chk($sformatf("abort_diff_c%0d", c), diff_v[1], 32'd0);
      chk($sformatf("abort_bout_c%0d", c), 32'(bout_v[1]), 32'd0);
    end
    @(posedge clk); #1;
    run_timed($urandom & 32'hFF, $urandom & 32'hFF, 1'($urandom));

    fork
      rand_run(0, 1, 3400);
      rand_run(1, 8, 3400);
      rand_run(2, 16, 3400);
    join

    repeat (3) @(posedge clk);
    chk("sb_empty_inst0", 32'(q0.size()), 32'd0);
    chk("sb_empty_inst1", 32'(q1.size()), 32'd0);
    chk("sb_empty_inst2", 32'(q2.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter size, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 clk  input  1  Single clock; all state changes on the rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 start  input  1  Request to begin a subtraction; sampled on every rising edge of clk.
REQ-005 a  input  size  Minuend; captured when start is accepted.
REQ-006 b  input  size  Subtrahend; captured when start is accepted.
REQ-007 bin  input  1  Borrow-in; captured when start is accepted.
REQ-008 busy  output  1  High while a subtraction is in progress.
REQ-009 done  output  1  One-cycle pulse; diff and bout are valid from this cycle onward.
REQ-010 diff  output  size  Result, (a - b - bin) mod 2^size.
REQ-011 bout  output  1  Borrow-out; 1 iff a < b + bin, treating all operands as unsigned.

Function
REQ-012 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-013 In IDLE or DONE, start=1 at edge k SHALL capture a, b and bin, clear the bit counter, and enter SHIFT.
REQ-014 In SHIFT, the block SHALL process exactly one bit per cycle, LSB first, over size cycles, using a single 1-bit full-subtractor and a registered borrow.
REQ-015 Bit computation per cycle: d_i = a_i ^ b_i ^ brw; brw_next = (~a_i & b_i) | (~(a_i ^ b_i) & brw); brw is initialised to the captured bin.
REQ-016 busy SHALL be 1 in cycles k+1 through k+size, and 0 in every other cycle.
REQ-017 After the last bit, the FSM SHALL enter DONE, so done=1 in cycle k+size+1, giving a total latency of size+1 cycles from start.
REQ-018 DONE SHALL last one cycle and then return to IDLE unless start=1, in which case it enters SHIFT (back-to-back operation, no bubble).
REQ-019 start asserted while in SHIFT SHALL be ignored; captured operands SHALL NOT change mid-operation.
REQ-020 diff and bout SHALL update only on the transition into DONE and SHALL hold until the next DONE or reset.
REQ-021 Wrap-around: the result is modulo 2^size, and bout reports the underflow; for example 0 - 1 gives all-ones with bout=1.
REQ-022 When size=1, the operation SHALL take exactly one SHIFT cycle, with done in cycle k+2.

Reset
REQ-023 rst=1 at an edge SHALL force the FSM to IDLE with busy=0, done=0, diff=0 and bout=0, and clear the internal shift registers, counter and borrow.
REQ-024 Reset SHALL override start in the same cycle and SHALL abort any operation in SHIFT without producing a done.
REQ-025 After rst deasserts, the block SHALL accept start on the first following edge.

Configuration
REQ-026 The macro SERIAL_SUBTRACTOR_SAT_EN SHALL select saturating behaviour.
REQ-027 With SERIAL_SUBTRACTOR_SAT_EN defined: when the final borrow is 1, diff SHALL be forced to 0 at DONE, and bout SHALL still report 1.
REQ-028 Without the macro: diff SHALL be the modular result of REQ-021, and no saturation logic SHALL be present.

Verification
REQ-029 size=8, a=8'h5A, b=8'h3C, bin=0, start pulsed at edge 0 -> busy high in cycles 1..8, done in cycle 9, diff=8'h1E, bout=0.
REQ-030 a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1; with SERIAL_SUBTRACTOR_SAT_EN -> diff=8'h00, bout=1.
REQ-031 a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bout=1; a=8'h80, b=8'h7F, bin=1 -> diff=8'h00, bout=0.
REQ-032 start held high continuously with new operands each DONE cycle -> done every 9 cycles, each result correct; operands changed during SHIFT -> no effect on the result.
REQ-033 rst asserted in cycle 4 of an operation -> busy=0 next cycle, no done pulse, diff=0, bout=0; a new start after reset -> correct result.
REQ-034 Random a, b and bin (10k vectors, sizes 1, 8 and 16) compared against the reference (a - b - bin) mod 2^size and (a < b + bin) -> zero mismatches.
